// File: rtl/misc_port_bridge.sv
// Byte command queue in front of the SDRAM controller misc port.
// Issues one strobe per command and returns read data in order.
package misc_port_bridge_pkg;

    typedef struct packed {
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  data;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT_LOW,
        WAIT_HIGH,
        GAP
    } state_t;

endpackage

module misc_port_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        host_wr,
    input  logic        host_rd,
    input  logic [24:0] host_addr,
    input  logic [7:0]  host_din,
    output logic [7:0]  host_dout,
    output logic        host_dout_valid,
    output logic        host_busy,
    output logic        host_idle,
    output logic        err_overflow,
    output logic        err_timeout,
    input  logic        err_clr,
    output logic [24:0] misc_addr,
    output logic [7:0]  misc_din,
    input  logic [7:0]  misc_dout,
    output logic        misc_rd,
    output logic        misc_we,
    input  logic        misc_ready
);

    import misc_port_bridge_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    cmd_t          fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          ovf_evt;
    cmd_t          push_cmd;
    cmd_t          head;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tmo_hit;
    logic          abort;

    logic          rd_q;
    logic          rd_d;
    logic          we_q;
    logic          we_d;
    logic [24:0]   addr_q;
    logic [24:0]   addr_d;
    logic [7:0]    din_q;
    logic [7:0]    din_d;
    logic [7:0]    dout_q;
    logic [7:0]    dout_d;
    logic          valid_q;
    logic          valid_d;
    logic          err_ovf_q;
    logic          err_ovf_d;
    logic          err_tmo_q;
    logic          err_tmo_d;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = (state_q == IDLE) && !empty;
    assign head    = fifo_q[rd_ptr_q];
    assign tmo_hit = (cnt_q == CW'(TIMEOUT));

    // A simultaneous write and read keeps the write only.
    always_comb begin
        push          = 1'b0;
        ovf_evt       = 1'b0;
        push_cmd.wr   = 1'b1;
        push_cmd.addr = host_addr;
        push_cmd.data = host_din;
        unique case (1'b1)
            host_wr && host_rd: begin
                push    = !full;
                ovf_evt = 1'b1;
            end
            host_wr && !host_rd: begin
                push    = !full;
                ovf_evt = full;
            end
            host_rd && !host_wr: begin
                push        = !full;
                ovf_evt     = full;
                push_cmd.wr = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_cmd;
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) state_d = STROBE;
            end
            STROBE: state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (!misc_ready)  state_d = WAIT_HIGH;
                else if (tmo_hit) state_d = GAP;
            end
            WAIT_HIGH: begin
                if (misc_ready)   state_d = GAP;
                else if (tmo_hit) state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_d    = rd_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    addr_d = head.addr;
                    din_d  = head.data;
                    we_d   = head.wr;
                    rd_d   = !head.wr;
                end
            end
            STROBE: cnt_d = '0;
            WAIT_LOW: begin
                if (!misc_ready) begin
                    cnt_d = '0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                    we_d  = 1'b0;
                    rd_d  = 1'b0;
                    if (rd_q) begin
                        dout_d  = 8'hFF;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (misc_ready) begin
                    we_d = 1'b0;
                    rd_d = 1'b0;
                    if (rd_q) begin
                        dout_d  = misc_dout;
                        valid_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                    we_d  = 1'b0;
                    rd_d  = 1'b0;
                    if (rd_q) begin
                        dout_d  = 8'hFF;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP:     ;
            default: ;
        endcase
    end

    // A clear racing a new error leaves the flag set.
    assign err_ovf_d = (err_ovf_q && !err_clr) || ovf_evt;
    assign err_tmo_d = (err_tmo_q && !err_clr) || abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            err_ovf_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            err_ovf_q <= err_ovf_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign misc_rd         = rd_q;
    assign misc_we         = we_q;
    assign misc_addr       = addr_q;
    assign misc_din        = din_q;
    assign host_dout       = dout_q;
    assign host_dout_valid = valid_q;
    assign host_busy       = full;
    assign host_idle       = empty && (state_q == IDLE);
    assign err_overflow    = err_ovf_q;
    assign err_timeout     = err_tmo_q;

endmodule

// File: tb/tb_misc_port_bridge.sv
// Randomized bench for misc_port_bridge with a behavioural SDRAM
// misc-port model and an in-order command/read-data scoreboard.
module tb_misc_port_bridge;

    localparam int DEPTH = 4;
    localparam int TO    = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        host_wr = 1'b0;
    logic        host_rd = 1'b0;
    logic [24:0] host_addr = '0;
    logic [7:0]  host_din = '0;
    logic [7:0]  host_dout;
    logic        host_dout_valid;
    logic        host_busy;
    logic        host_idle;
    logic        err_overflow;
    logic        err_timeout;
    logic        err_clr = 1'b0;
    logic [24:0] misc_addr;
    logic [7:0]  misc_din;
    logic [7:0]  misc_dout = '0;
    logic        misc_rd;
    logic        misc_we;
    logic        misc_ready = 1'b1;

    misc_port_bridge #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .host_wr        (host_wr),
        .host_rd        (host_rd),
        .host_addr      (host_addr),
        .host_din       (host_din),
        .host_dout      (host_dout),
        .host_dout_valid(host_dout_valid),
        .host_busy      (host_busy),
        .host_idle      (host_idle),
        .err_overflow   (err_overflow),
        .err_timeout    (err_timeout),
        .err_clr        (err_clr),
        .misc_addr      (misc_addr),
        .misc_din       (misc_din),
        .misc_dout      (misc_dout),
        .misc_rd        (misc_rd),
        .misc_we        (misc_we),
        .misc_ready     (misc_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [24:0] a;
        logic [7:0]  d;
    } cmd_t;

    int   total = 0;
    int   bad = 0;
    cmd_t exp_cmd[$];
    logic [7:0] exp_rd[$];
    logic [7:0] ref_mem[logic [24:0]];
    logic [7:0] ctl_mem[logic [24:0]];
    bit   kinds[$];
    int   n_rise = 0;
    int   n_valid = 0;
    int   last_hi = 0;

    // controller model: 0 fixed delays, 1 random delays, 2 never responds
    int   mode = 0;
    int   drop_at = 2;
    int   high_at = 8;

    function automatic logic [7:0] dflt(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    initial begin : ctl_model
        int  k;
        bit  act;
        bit  pstb;
        k = 0;
        act = 0;
        pstb = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                misc_ready <= 1'b1;
                act = 0;
                pstb = 0;
                k = 0;
            end else begin
                if ((misc_we || misc_rd) && !pstb) begin
                    if (misc_we) begin
                        ctl_mem[misc_addr] = misc_din;
                    end else if (ctl_mem.exists(misc_addr)) begin
                        misc_dout <= ctl_mem[misc_addr];
                    end else begin
                        misc_dout <= dflt(misc_addr);
                    end
                    if (mode == 1) begin
                        drop_at = $urandom_range(1, 6);
                        high_at = drop_at + $urandom_range(1, 10);
                    end
                    k = 1;
                    act = (mode != 2);
                    if (act && drop_at == 1) misc_ready <= 1'b0;
                end else if (act) begin
                    k++;
                    if (k == drop_at) misc_ready <= 1'b0;
                    if (k == high_at) begin
                        misc_ready <= 1'b1;
                        act = 0;
                    end
                end
                pstb = misc_we || misc_rd;
            end
        end
    end

    initial begin : monitor
        bit          pstb;
        bit          stb;
        bit          cap_w;
        bit          stab_bad;
        logic [24:0] cap_a;
        logic [7:0]  cap_d;
        int          lo;
        int          hi;
        cmd_t        c;
        logic [7:0]  e;
        pstb = 0;
        cap_w = 0;
        stab_bad = 0;
        cap_a = '0;
        cap_d = '0;
        lo = -1;
        hi = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pstb = 0;
                lo = -1;
                hi = 0;
                continue;
            end
            stb = misc_we || misc_rd;
            if (stb && !pstb) begin
                n_rise++;
                kinds.push_back(misc_we);
                total++;
                if (exp_cmd.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected we=%b rd=%b addr=%h",
                             misc_we, misc_rd, misc_addr);
                end else begin
                    c = exp_cmd.pop_front();
                    if (misc_we !== c.w || misc_rd !== !c.w ||
                        misc_addr !== c.a || (c.w && misc_din !== c.d)) begin
                        bad++;
                        $display("FAIL strobe_cmd got we=%b rd=%b a=%h d=%h want w=%b a=%h d=%h",
                                 misc_we, misc_rd, misc_addr, misc_din,
                                 c.w, c.a, c.d);
                    end
                end
                if (lo >= 0) begin
                    total++;
                    if (lo < 2) begin
                        bad++;
                        $display("FAIL strobe_low_time got %0d want >=2", lo);
                    end
                end
                cap_a = misc_addr;
                cap_d = misc_din;
                cap_w = misc_we;
                stab_bad = 0;
                hi = 1;
            end else if (stb) begin
                hi++;
                if (misc_addr !== cap_a || misc_we !== cap_w ||
                    (cap_w && misc_din !== cap_d)) stab_bad = 1;
            end else if (pstb) begin
                last_hi = hi;
                lo = 1;
                if (misc_addr !== cap_a || (cap_w && misc_din !== cap_d))
                    stab_bad = 1;
                total++;
                if (stab_bad) begin
                    bad++;
                    $display("FAIL addr_stable got a=%h d=%h want a=%h d=%h",
                             misc_addr, misc_din, cap_a, cap_d);
                end
            end else if (lo >= 0 && lo < 1000) begin
                lo++;
            end
            if (host_dout_valid) begin
                n_valid++;
                total++;
                if (exp_rd.size() == 0) begin
                    bad++;
                    $display("FAIL read_unexpected dout=%h", host_dout);
                end else begin
                    e = exp_rd.pop_front();
                    if (host_dout !== e) begin
                        bad++;
                        $display("FAIL read_data got %h want %h", host_dout, e);
                    end
                end
            end
            pstb = stb;
        end
    end

    task automatic push(input bit wr, input bit rd, input logic [24:0] a,
                        input logic [7:0] d, input bit acc, input bit clr,
                        input bit ab);
        cmd_t c;
        host_wr = wr;
        host_rd = rd;
        host_addr = a;
        host_din = d;
        err_clr = clr;
        @(negedge clk);
        host_wr = 0;
        host_rd = 0;
        err_clr = 0;
        if (acc && (wr || rd)) begin
            c.w = wr;
            c.a = a;
            c.d = d;
            exp_cmd.push_back(c);
            if (wr) begin
                ref_mem[a] = d;
            end else if (ab) begin
                exp_rd.push_back(8'hFF);
            end else if (ref_mem.exists(a)) begin
                exp_rd.push_back(ref_mem[a]);
            end else begin
                exp_rd.push_back(dflt(a));
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (host_idle && exp_cmd.size() == 0 && exp_rd.size() == 0) begin
                done = 1;
                break;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_drain got idle=%b cmds=%0d reads=%0d want idle",
                     tag, host_idle, exp_cmd.size(), exp_rd.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({misc_rd, misc_we} !== 2'b00) begin
            bad++;
            $display("FAIL reset_strobes got %b want 00", {misc_rd, misc_we});
        end
        total++;
        if (misc_addr !== 25'h0 || misc_din !== 8'h0) begin
            bad++;
            $display("FAIL reset_addr got %h/%h want 0/0", misc_addr, misc_din);
        end
        total++;
        if (host_dout !== 8'h0 || host_dout_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_dout got %h/%b want 00/0", host_dout, host_dout_valid);
        end
        total++;
        if (host_busy !== 1'b0 || host_idle !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy_idle got %b%b want 01", host_busy, host_idle);
        end
        total++;
        if (err_overflow !== 1'b0 || err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got %b%b want 00", err_overflow, err_timeout);
        end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        int v0;
        mode = 0;
        drop_at = 2;
        high_at = 8;
        v0 = n_valid;
        push(1, 0, 25'h0_1234, 8'hA5, 1, 0, 0);
        wait_idle(100, "single_write");
        total++;
        if (last_hi !== 9) begin
            bad++;
            $display("FAIL write_strobe_len got %0d want 9", last_hi);
        end
        total++;
        if (n_valid !== v0 || host_idle !== 1'b1) begin
            bad++;
            $display("FAIL write_no_valid got valids=%0d idle=%b want %0d/1",
                     n_valid, host_idle, v0);
        end
    endtask

    task automatic test_single_read();
        int v0;
        mode = 0;
        drop_at = 2;
        high_at = 8;
        ctl_mem[25'h1F_FFFF] = 8'h3C;
        ref_mem[25'h1F_FFFF] = 8'h3C;
        v0 = n_valid;
        push(0, 1, 25'h1F_FFFF, 8'h00, 1, 0, 0);
        push(1, 0, 25'h00_0042, 8'h17, 1, 0, 0);
        wait_idle(100, "single_read");
        total++;
        if (n_valid !== v0 + 1 || host_dout !== 8'h3C) begin
            bad++;
            $display("FAIL read_result got n=%0d dout=%h want n=%0d dout=3c",
                     n_valid - v0, host_dout, 1);
        end
    endtask

    task automatic test_overflow();
        mode = 0;
        drop_at = 3;
        high_at = 13;
        push(1, 0, 25'h00_0100, 8'h01, 1, 0, 0);
        repeat (2) @(negedge clk);
        for (int i = 1; i <= DEPTH; i++) begin
            push(i[0], !i[0], 25'h00_0100 + 25'(i), 8'(i), 1, 0, 0);
            total++;
            if (host_busy !== (i == DEPTH)) begin
                bad++;
                $display("FAIL busy_after_push%0d got %b want %b",
                         i, host_busy, (i == DEPTH));
            end
        end
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_early got %b want 0", err_overflow);
        end
        push(1, 0, 25'h00_01FF, 8'hEE, 0, 0, 0);
        total++;
        if (err_overflow !== 1'b1 || host_busy !== 1'b1) begin
            bad++;
            $display("FAIL ovf_dropped got ovf=%b busy=%b want 1/1",
                     err_overflow, host_busy);
        end
        wait_idle(400, "overflow");
        push(0, 0, 25'h0, 8'h0, 0, 1, 0);
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got %b want 0", err_overflow);
        end
        push(1, 1, 25'h00_0200, 8'h5C, 1, 1, 0);
        total++;
        if (err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_clr_race got %b want 1", err_overflow);
        end
        wait_idle(100, "wr_rd_both");
        push(0, 0, 25'h0, 8'h0, 0, 1, 0);
    endtask

    task automatic test_interleave();
        int v0;
        mode = 1;
        kinds.delete();
        v0 = n_valid;
        push(1, 0, 25'h0A_0001, 8'h91, 1, 0, 0);
        push(0, 1, 25'h0A_0001, 8'h00, 1, 0, 0);
        push(1, 0, 25'h0A_0002, 8'h6B, 1, 0, 0);
        push(0, 1, 25'h0B_7777, 8'h00, 1, 0, 0);
        wait_idle(200, "interleave");
        total++;
        if (n_valid !== v0 + 2) begin
            bad++;
            $display("FAIL interleave_valids got %0d want 2", n_valid - v0);
        end
        total++;
        if (kinds.size() != 4 ||
            {kinds[0], kinds[1], kinds[2], kinds[3]} !== 4'b1010) begin
            bad++;
            $display("FAIL interleave_kinds got n=%0d want we,rd,we,rd",
                     kinds.size());
        end
    endtask

    task automatic test_random();
        logic [24:0] pool [8];
        int          v0;
        int          nrd;
        bit          w;
        bit          ok;
        mode = 1;
        for (int i = 0; i < 8; i++) pool[i] = 25'($urandom);
        v0 = n_valid;
        nrd = 0;
        for (int n = 0; n < 40; n++) begin
            ok = 0;
            for (int t = 0; t < 200; t++) begin
                if (!host_busy) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL random_busy_stuck got busy=%b want 0", host_busy);
                break;
            end
            w = $urandom_range(0, 1) == 1;
            if (!w) nrd++;
            push(w, !w, pool[$urandom_range(0, 7)], 8'($urandom), 1, 0, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(2000, "random");
        total++;
        if (n_valid - v0 !== nrd) begin
            bad++;
            $display("FAIL random_valids got %0d want %0d", n_valid - v0, nrd);
        end
    endtask

    task automatic test_timeout();
        int v0;
        mode = 2;
        v0 = n_valid;
        push(0, 1, 25'h03_3333, 8'h00, 1, 0, 1);
        wait_idle(100, "timeout");
        total++;
        if (last_hi !== TO + 2) begin
            bad++;
            $display("FAIL timeout_strobe_len got %0d want %0d", last_hi, TO + 2);
        end
        total++;
        if (err_timeout !== 1'b1 || n_valid !== v0 + 1 || host_dout !== 8'hFF) begin
            bad++;
            $display("FAIL timeout_abort got err=%b n=%0d dout=%h want 1/1/ff",
                     err_timeout, n_valid - v0, host_dout);
        end
        push(0, 0, 25'h0, 8'h0, 0, 1, 0);
        total++;
        if (err_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear got %b want 0", err_timeout);
        end
        mode = 0;
    endtask

    task automatic test_reset_mid();
        int  rc;
        int  vc;
        bit  seen;
        mode = 0;
        drop_at = 2;
        high_at = 12;
        push(1, 0, 25'h1C_0000, 8'h11, 1, 0, 0);
        push(0, 1, 25'h1C_0001, 8'h00, 1, 0, 0);
        push(1, 0, 25'h1C_0002, 8'h33, 1, 0, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (misc_ready == 1'b0) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_mid_reach got ready=%b want 0", misc_ready);
        end
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        total++;
        if ({misc_we, misc_rd} !== 2'b00) begin
            bad++;
            $display("FAIL reset_async_strobe got %b want 00", {misc_we, misc_rd});
        end
        exp_cmd.delete();
        exp_rd.delete();
        repeat (2) @(negedge clk);
        reset_n = 1;
        rc = n_rise;
        vc = n_valid;
        @(negedge clk);
        total++;
        if (host_idle !== 1'b1 || host_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle got idle=%b busy=%b want 1/0",
                     host_idle, host_busy);
        end
        repeat (30) @(negedge clk);
        total++;
        if (n_rise !== rc || n_valid !== vc) begin
            bad++;
            $display("FAIL reset_mid_quiet got rises=%0d valids=%0d want 0/0",
                     n_rise - rc, n_valid - vc);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_overflow();
        test_interleave();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/misc_port_bridge.md
Name: misc_port_bridge

Overview:
- Queues byte read/write commands from a host-side stream (disk/ROM loader, debugger, DMA) and issues them one at a time on the SDRAM controller's misc port.
- Sits directly upstream of the SDRAM controller's misc_* interface and drives its edge-triggered misc_rd/misc_we strobes.
- Waits out the controller's misc_ready low/high handshake, then returns read data to the host in command order.

Parameters:
- FIFO_DEPTH, 4, number of queued commands; power of two, minimum 2.
- TIMEOUT, 4095, maximum cycles to wait for each misc_ready phase before aborting a command.

Ports:
- clk  in  1  system clock (~100 MHz, same clock as the SDRAM controller).
- reset_n  in  1  asynchronous active-low reset.
- host_wr  in  1  one-cycle pulse: push a write command.
- host_rd  in  1  one-cycle pulse: push a read command.
- host_addr  in  25  byte address of the command.
- host_din  in  8  write data.
- host_dout  out  8  read result.
- host_dout_valid  out  1  one-cycle pulse when host_dout is updated.
- host_busy  out  1  FIFO full; host must not push.
- host_idle  out  1  FIFO empty and FSM in IDLE.
- err_overflow  out  1  sticky: a push was dropped.
- err_timeout  out  1  sticky: a command was aborted.
- err_clr  in  1  clears both sticky flags.
- misc_addr  out  25  address to the controller.
- misc_din  out  8  write data to the controller.
- misc_dout  in  8  read data from the controller.
- misc_rd  out  1  read strobe; controller acts on its rising edge.
- misc_we  out  1  write strobe; controller acts on its rising edge.
- misc_ready  in  1  controller status: goes low after a strobe edge, high on completion.

Behaviour:
- Reset values (async, reset_n low): misc_rd=0, misc_we=0, misc_addr=0, misc_din=0, host_dout=0, host_dout_valid=0, host_busy=0, host_idle=1, both err flags 0, FIFO empty, FSM in IDLE, timeout counter 0.
- FIFO:
  - Entry is {is_write, addr[24:0], data[7:0]}.
  - host_busy = count==FIFO_DEPTH.
  - A push while full is dropped and sets err_overflow.
  - host_wr and host_rd together: only the write is pushed; the read is dropped and sets err_overflow.
  - A push and a pop in the same cycle while full: the push is dropped (fullness is evaluated before the pop).
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, STROBE, WAIT_LOW, WAIT_HIGH, GAP.
  - IDLE: if FIFO non-empty, pop the head; register misc_addr/misc_din; set misc_we (write) or misc_rd (read); go to STROBE. Strobe goes high the cycle after the pop.
  - STROBE: hold the strobe; clear the timeout counter; go to WAIT_LOW.
  - WAIT_LOW: hold the strobe until misc_ready==0, then go to WAIT_HIGH and clear the counter.
  - WAIT_HIGH: hold the strobe until misc_ready==1. On completion:
    - read: host_dout<=misc_dout and host_dout_valid pulses one cycle.
    - both: drop the strobe; go to GAP.
  - GAP: strobe held low exactly one cycle (guarantees a fresh rising edge for the next command); go to IDLE.
- Minimum strobe low time is 2 cycles: the GAP cycle plus the IDLE cycle.
- misc_addr/misc_din are stable from strobe rise until GAP ends.
- Timeout:
  - The counter increments in WAIT_LOW and WAIT_HIGH.
  - On reaching TIMEOUT: drop the strobe, set err_timeout, go to GAP.
  - An aborted read still pulses host_dout_valid with host_dout=8'hFF.
- Exactly one host_dout_valid pulse per popped read; results are returned in push order.
- err_clr and a new error in the same cycle: the flag ends up set.
- host_idle = FIFO empty & state==IDLE.
- Reset asserted mid-command: strobes drop immediately; the FIFO and pending commands are discarded; no host_dout_valid is produced.

Test Plan:
- Single write (addr 25'h0_1234, data 8'hA5); controller model drops ready 2 cycles after misc_we rises and raises it 6 cycles later -> misc_we high exactly 9 cycles; misc_addr=25'h0_1234 and misc_din=8'hA5 stable throughout; no host_dout_valid; host_idle returns 1.
- Read at 25'h1F_FFFF, model returns 8'h3C -> one host_dout_valid with host_dout=8'h3C; misc_rd low at least 2 cycles before any next strobe.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and the controller stalled -> host_busy asserts after the 4th push; the 5th is dropped and sets err_overflow; the 4 commands are issued in order.
- Interleave write, read, write, read -> two valid pulses, data returned in order; strobe rising edges alternate misc_we/misc_rd.
- Model never drops misc_ready, TIMEOUT=15 -> strobe drops after 16 cycles of waiting; err_timeout=1; read returns 8'hFF; err_clr clears the flag.
- Assert reset_n low during WAIT_HIGH with 2 queued commands -> strobes go low asynchronously; after release host_idle=1 and no further strobes occur.
